chart_sequencer: RTL and testbench
==================================

Name: chart_sequencer

Overview:
- Parametrised successor of the fixed-chart note generator.
- Holds a runtime-loadable chart of up to MAX_NOTES entries (time, track, pitch) and compares each entry against the game timer. It emits one-cycle spawn pulses on NUM_TRACKS tracks, with a programmable lead time.
- Sits between game_timer and the per-track note-lane logic and LCD renderer. Signals end of song after END_DELAY.

Parameters:
- NUM_TRACKS, 4, number of note lanes (1..8)
- MAX_NOTES, 256, chart memory depth (power of 2)
- TIME_W, 32, width of timestamps in ms
- PITCH_W, 32, width of pitch/divider value
- END_DELAY, 5000, ms after last note time before o_game_end
- AW, $clog2(MAX_NOTES), address width (derived; do not override)
- TW, $clog2(NUM_TRACKS+1), track field width (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_cur_time  in  TIME_W  current song time (ms), monotonic while running
- i_start  in  1  one-cycle pulse: arm and start playback from entry 0
- i_abort  in  1  one-cycle pulse: stop playback, return to IDLE
- i_lead_ms  in  TIME_W  spawn lead; entry fires when i_cur_time + i_lead_ms >= time
- i_note_count  in  AW+1  number of valid chart entries (0..MAX_NOTES), sampled on i_start
- i_wr_en  in  1  chart write strobe
- i_wr_addr  in  AW  chart write address
- i_wr_time  in  TIME_W  entry timestamp
- i_wr_track  in  TW  entry track: 0 = rest, 1..NUM_TRACKS = lane
- i_wr_pitch  in  PITCH_W  entry pitch
- o_note  out  NUM_TRACKS  one-hot spawn pulse; bit k = track k+1
- o_gen_pitch  out  PITCH_W  pitch of most recent fired non-rest entry
- o_note_idx  out  AW+1  index of next entry awaiting fire
- o_busy  out  1  high in RUN and DRAIN
- o_game_end  out  1  sticky end-of-song flag
- o_chart_err  out  1  sticky: non-monotonic time or invalid track encountered

Behaviour:
- Reset (async): all outputs 0, state IDLE, loop offset 0. Chart memory is not cleared.
- Memory: register array with 1-cycle registered write and combinational read at the current index.
- Writes are accepted only in IDLE or DONE. They are ignored in RUN and DRAIN.
- States:
  - IDLE: wait for i_start.
  - RUN: fire entries.
  - DRAIN: wait for the end delay.
  - DONE: o_game_end = 1.
- IDLE/DONE on i_start:
  - latch count, clear o_note_idx, o_game_end and o_chart_err;
  - go to RUN, or to DRAIN if count = 0.
- RUN, fire rule:
  - entry e = mem[idx] fires when {1'b0,i_cur_time} + {1'b0,i_lead_ms} >= {1'b0,e.time], compared in TIME_W+1 bits (no overflow).
  - At most one entry fires per cycle. The pulse appears the cycle after the condition is true.
  - Entries with equal timestamps fire on consecutive cycles in index order.
  - Firing an entry:
    - track 1..NUM_TRACKS: o_note bit set for 1 cycle and o_gen_pitch updated;
    - track 0: idx advances, no pulse, pitch held;
    - track > NUM_TRACKS: no pulse, o_chart_err set, idx advances.
  - If e.time < the previously fired time, set o_chart_err and still fire.
  - After the entry at index count-1 fires, latch last_time = e.time and go to DRAIN.
- DRAIN:
  - when i_cur_time >= last_time + END_DELAY (TIME_W+1-bit add), set o_game_end and go to DONE;
  - with count = 0, last_time = 0.
- o_note is 0 in every cycle where nothing fires. o_busy = (state == RUN or DRAIN).
- i_abort in any state: go to IDLE next cycle, o_note forced 0, o_game_end cleared. If i_abort and i_start arrive in the same cycle, i_abort wins.
- i_start while RUN or DRAIN: ignored.

Optional Feature:
- Macro CHART_LOOP_EN.
- Defined:
  - adds input i_loop (1 bit) and parameter LOOP_GAP (default 1000 ms);
  - when the last entry fires and i_loop = 1, idx wraps to 0 and the offset register += last_time + LOOP_GAP;
  - the fire compare uses e.time + offset;
  - no DRAIN and no o_game_end while looping; a loop with i_loop = 0 ends normally;
  - offset clears on i_start, i_abort and rst.
- Undefined: no i_loop port, no offset logic; offset is treated as 0.

Test Plan:
- Load 3 entries {(1000,1,D4=85132),(1120,2,42565),(1360,0,0)}, count = 3, lead = 0, start, sweep time 0..7000 → o_note = 0001 at t = 1000, 0010 at t = 1120, no pulse at 1360, o_gen_pitch = 42565, o_game_end asserts at t = 6360.
- Two entries both at t = 500 on tracks 1 and 3, time jumps 0 → 600 → pulses 0001 then 0100 on consecutive cycles, o_note_idx 0 → 1 → 2.
- lead = 200, entry at 1000 → pulse when i_cur_time = 800. lead = 0xFFFF_FFFF with time = 1 → fires immediately, no wrap error.
- Entries at times 2000 then 1500; entry with track = 7 (NUM_TRACKS = 4) → o_chart_err = 1, both still consumed, no pulse for the track-7 entry.
- i_abort mid-RUN at idx = 5 → IDLE next cycle, o_busy = 0. Write attempts during RUN leave memory unchanged (readback via a replay after restart). count = 0 start → o_game_end at t = 5000.
- CHART_LOOP_EN, i_loop = 1, 2 entries at 100 and 200 → second pass fires at 1300 and 1400. Drop i_loop during the second pass → o_game_end at 1400 + 5000.

Source files
------------

// File: rtl/chart_sequencer_if.sv
// Control, chart-write and status bundle for chart_sequencer.
// The loop-enable input exists only when CHART_LOOP_EN is defined.
interface chart_sequencer_if #(
  parameter int unsigned NUM_TRACKS = 4,
  parameter int unsigned MAX_NOTES  = 256,
  parameter int unsigned TIME_W     = 32,
  parameter int unsigned PITCH_W    = 32
);
  localparam int unsigned AW = $clog2(MAX_NOTES);
  localparam int unsigned TW = $clog2(NUM_TRACKS + 1);

  logic [TIME_W-1:0]     i_cur_time;
  logic                  i_start;
  logic                  i_abort;
  logic [TIME_W-1:0]     i_lead_ms;
  logic [AW:0]           i_note_count;
  logic                  i_wr_en;
  logic [AW-1:0]         i_wr_addr;
  logic [TIME_W-1:0]     i_wr_time;
  logic [TW-1:0]         i_wr_track;
  logic [PITCH_W-1:0]    i_wr_pitch;
`ifdef CHART_LOOP_EN
  logic                  i_loop;
`endif
  logic [NUM_TRACKS-1:0] o_note;
  logic [PITCH_W-1:0]    o_gen_pitch;
  logic [AW:0]           o_note_idx;
  logic                  o_busy;
  logic                  o_game_end;
  logic                  o_chart_err;

  modport master (
    output i_cur_time, i_start, i_abort, i_lead_ms, i_note_count,
           i_wr_en, i_wr_addr, i_wr_time, i_wr_track, i_wr_pitch,
`ifdef CHART_LOOP_EN
           i_loop,
`endif
    input  o_note, o_gen_pitch, o_note_idx, o_busy, o_game_end, o_chart_err
  );

  modport slave (
    input  i_cur_time, i_start, i_abort, i_lead_ms, i_note_count,
           i_wr_en, i_wr_addr, i_wr_time, i_wr_track, i_wr_pitch,
`ifdef CHART_LOOP_EN
           i_loop,
`endif
    output o_note, o_gen_pitch, o_note_idx, o_busy, o_game_end, o_chart_err
  );
endinterface

// File: rtl/chart_sequencer.sv
// Runtime-loadable chart player: fires one chart entry per cycle against the game
// timer and flags end of song. Define CHART_LOOP_EN for looping playback.
module chart_sequencer #(
  parameter int unsigned NUM_TRACKS = 4,
  parameter int unsigned MAX_NOTES  = 256,
  parameter int unsigned TIME_W     = 32,
  parameter int unsigned PITCH_W    = 32,
  parameter int unsigned END_DELAY  = 5000
`ifdef CHART_LOOP_EN
  ,
  parameter int unsigned LOOP_GAP   = 1000
`endif
) (
  input logic              clk,
  input logic              rst,
  chart_sequencer_if.slave bus
);
  localparam int unsigned AW = $clog2(MAX_NOTES);
  localparam int unsigned TW = $clog2(NUM_TRACKS + 1);
  localparam logic [TIME_W:0] END_D = (TIME_W + 1)'(END_DELAY);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q;
  logic [AW:0]           idx_q;
  logic [AW:0]           count_q;
  logic [TIME_W-1:0]     last_time_q;
  logic [TIME_W-1:0]     prev_time_q;
  logic [NUM_TRACKS-1:0] note_q;
  logic [PITCH_W-1:0]    pitch_q;
  logic                  end_q;
  logic                  err_q;

  logic [TIME_W-1:0]     mem_time_q  [MAX_NOTES];
  logic [TW-1:0]         mem_track_q [MAX_NOTES];
  logic [PITCH_W-1:0]    mem_pitch_q [MAX_NOTES];

  logic [TIME_W-1:0]     e_time;
  logic [TW-1:0]         e_track;
  logic [PITCH_W-1:0]    e_pitch;
  logic [TIME_W:0]       lhs;
  logic [TIME_W:0]       rhs;
  logic [AW:0]           idx_inc;
  logic                  fire;
  logic                  is_last;
  logic                  track_ok;
  logic                  drain_done;
  logic                  do_start;
  logic                  wr_ok;
  logic [NUM_TRACKS-1:0] note_hot;
  logic [TIME_W-1:0]     offset;
  logic                  loop_req;

  assign wr_ok    = (state_q == IDLE) || (state_q == DONE);
  assign do_start = bus.i_start && !bus.i_abort && wr_ok;

  // Chart memory is deliberately left out of reset so a loaded chart survives rst.
  always_ff @(posedge clk) begin
    if (bus.i_wr_en && wr_ok) begin
      mem_time_q[bus.i_wr_addr]  <= bus.i_wr_time;
      mem_track_q[bus.i_wr_addr] <= bus.i_wr_track;
      mem_pitch_q[bus.i_wr_addr] <= bus.i_wr_pitch;
    end
  end

  assign e_time  = mem_time_q[idx_q[AW-1:0]];
  assign e_track = mem_track_q[idx_q[AW-1:0]];
  assign e_pitch = mem_pitch_q[idx_q[AW-1:0]];

`ifdef CHART_LOOP_EN
  logic [TIME_W-1:0] offset_q;

  assign offset   = offset_q;
  assign loop_req = bus.i_loop;

  // Each wrap pushes the whole chart later by one song length plus the gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q <= '0;
    end else if (bus.i_abort || do_start) begin
      offset_q <= '0;
    end else if (fire && is_last && loop_req) begin
      offset_q <= offset_q + e_time + TIME_W'(LOOP_GAP);
    end
  end
`else
  assign offset   = '0;
  assign loop_req = 1'b0;
`endif

  // Sums are one bit wider than the operands so a huge lead cannot wrap.
  always_comb begin
    lhs        = {1'b0, bus.i_cur_time} + {1'b0, bus.i_lead_ms};
    rhs        = {1'b0, e_time} + {1'b0, offset};
    idx_inc    = idx_q + 1'b1;
    fire       = (state_q == RUN) && (lhs >= rhs);
    is_last    = (idx_inc == count_q);
    track_ok   = (e_track <= TW'(NUM_TRACKS));
    drain_done = ({1'b0, bus.i_cur_time} >= ({1'b0, last_time_q} + END_D));
    note_hot   = '0;
    for (int unsigned k = 0; k < NUM_TRACKS; k++) begin
      note_hot[k] = (e_track == TW'(k + 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      count_q     <= '0;
      last_time_q <= '0;
      prev_time_q <= '0;
      note_q      <= '0;
      pitch_q     <= '0;
      end_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      note_q <= '0;
      if (bus.i_abort) begin
        state_q <= IDLE;
        end_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            if (bus.i_start) begin
              count_q     <= bus.i_note_count;
              idx_q       <= '0;
              end_q       <= 1'b0;
              err_q       <= 1'b0;
              prev_time_q <= '0;
              last_time_q <= '0;
              state_q     <= (bus.i_note_count == '0) ? DRAIN : RUN;
            end
          end
          RUN: begin
            if (fire) begin
              prev_time_q <= e_time;
              if ((e_time < prev_time_q) || !track_ok) begin
                err_q <= 1'b1;
              end
              // note_hot is all-zero for rests and out-of-range tracks
              note_q <= note_hot;
              if (note_hot != '0) begin
                pitch_q <= e_pitch;
              end
              if (is_last) begin
                last_time_q <= e_time + offset;
                if (loop_req) begin
                  idx_q       <= '0;
                  prev_time_q <= '0;
                end else begin
                  idx_q   <= idx_inc;
                  state_q <= DRAIN;
                end
              end else begin
                idx_q <= idx_inc;
              end
            end
          end
          DRAIN: begin
            if (drain_done) begin
              end_q   <= 1'b1;
              state_q <= DONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_note      = note_q;
  assign bus.o_gen_pitch = pitch_q;
  assign bus.o_note_idx  = idx_q;
  assign bus.o_busy      = (state_q == RUN) || (state_q == DRAIN);
  assign bus.o_game_end  = end_q;
  assign bus.o_chart_err = err_q;
endmodule

// File: tb/tb_chart_sequencer.sv
// Directed bench for chart_sequencer: expected spawns are queued as the chart is
// loaded and popped as pulses appear while the song timer is swept.
module tb_chart_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  chart_sequencer_if bus ();

  chart_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  note;
    int          t;
    logic [31:0] pitch;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   end_seen = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input int t, input int trk, input int pitch);
    bus.i_wr_addr  = 8'(addr);
    bus.i_wr_time  = 32'(t);
    bus.i_wr_track = 3'(trk);
    bus.i_wr_pitch = 32'(pitch);
    bus.i_wr_en    = 1'b1;
    tick();
    bus.i_wr_en    = 1'b0;
  endtask

  task automatic start(input int cnt, input int cur);
    bus.i_note_count = 9'(cnt);
    bus.i_cur_time   = 32'(cur);
    bus.i_start      = 1'b1;
    tick();
    bus.i_start      = 1'b0;
    end_seen         = 1'b0;
  endtask

  task automatic abort();
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
  endtask

  task automatic push(input int note, input int t, input int pitch);
    exp_t e;
    e.note  = 4'(note);
    e.t     = t;
    e.pitch = 32'(pitch);
    sb.push_back(e);
  endtask

  // exp_end < 0 means the song must not end inside this sweep.
  task automatic sweep(input int lo, input int hi, input int exp_end);
    exp_t e;
    for (int t = lo; t <= hi; t++) begin
      bus.i_cur_time = 32'(t);
      tick();
      if (bus.o_note !== 4'b0) begin
        if (sb.size() == 0) begin
          chk("stray_note", bus.o_note, 0);
        end else begin
          e = sb.pop_front();
          chk("note_bits", bus.o_note, e.note);
          chk("note_time", t, e.t);
          chk("note_pitch", bus.o_gen_pitch, e.pitch);
        end
      end
      if (bus.o_game_end && !end_seen) begin
        end_seen = 1'b1;
        if (exp_end < 0) chk("stray_end", bus.o_game_end, 0);
        else             chk("end_time", t, exp_end);
      end
    end
  endtask

  initial begin
    bus.i_cur_time   = '0;
    bus.i_start      = 1'b0;
    bus.i_abort      = 1'b0;
    bus.i_lead_ms    = '0;
    bus.i_note_count = '0;
    bus.i_wr_en      = 1'b0;
    bus.i_wr_addr    = '0;
    bus.i_wr_time    = '0;
    bus.i_wr_track   = '0;
    bus.i_wr_pitch   = '0;
`ifdef CHART_LOOP_EN
    bus.i_loop       = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_note", bus.o_note, 0);
    chk("rst_pitch", bus.o_gen_pitch, 0);
    chk("rst_idx", bus.o_note_idx, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_end", bus.o_game_end, 0);
    chk("rst_err", bus.o_chart_err, 0);

    // Basic three-entry song with a trailing rest
    wr(0, 1000, 1, 85132);
    wr(1, 1120, 2, 42565);
    wr(2, 1360, 0, 0);
    push(1, 1000, 85132);
    push(2, 1120, 42565);
    start(3, 0);
    chk("t1_busy", bus.o_busy, 1);
    chk("t1_idx0", bus.o_note_idx, 0);
    sweep(0, 7000, 6360);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_end", bus.o_game_end, 1);
    chk("t1_pitch", bus.o_gen_pitch, 42565);
    chk("t1_idx", bus.o_note_idx, 3);
    chk("t1_busy_done", bus.o_busy, 0);
    chk("t1_err", bus.o_chart_err, 0);

    // Equal timestamps fire on consecutive cycles
    wr(0, 500, 1, 111);
    wr(1, 500, 3, 333);
    start(2, 0);
    chk("t2_end_clr", bus.o_game_end, 0);
    tick();
    chk("t2_idle_note", bus.o_note, 0);
    bus.i_cur_time = 600;
    tick();
    chk("t2_note_a", bus.o_note, 4'b0001);
    chk("t2_idx_a", bus.o_note_idx, 1);
    tick();
    chk("t2_note_b", bus.o_note, 4'b0100);
    chk("t2_idx_b", bus.o_note_idx, 2);
    chk("t2_pitch", bus.o_gen_pitch, 333);
    tick();
    chk("t2_note_off", bus.o_note, 0);
    chk("t2_drain_busy", bus.o_busy, 1);
    abort();
    chk("t2_abort_busy", bus.o_busy, 0);

    // Lead time, then a near-maximal lead that must not wrap
    wr(0, 1000, 2, 777);
    bus.i_lead_ms = 200;
    push(2, 800, 777);
    start(1, 0);
    sweep(0, 900, -1);
    chk("t3_sb_empty", sb.size(), 0);
    abort();
    wr(0, 1, 1, 5);
    bus.i_lead_ms = 32'hFFFF_FFFF;
    start(1, 1);
    tick();
    chk("t3_bigl_note", bus.o_note, 4'b0001);
    chk("t3_bigl_err", bus.o_chart_err, 0);
    abort();
    bus.i_lead_ms = '0;

    // Non-monotonic time and an invalid track
    wr(0, 2000, 1, 10);
    wr(1, 1500, 2, 20);
    wr(2, 1600, 7, 30);
    wr(3, 1700, 4, 40);
    push(1, 2000, 10);
    push(2, 2001, 20);
    push(8, 2003, 40);
    start(4, 0);
    chk("t4_err_clr", bus.o_chart_err, 0);
    sweep(0, 2100, -1);
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_err", bus.o_chart_err, 1);
    chk("t4_pitch", bus.o_gen_pitch, 40);
    chk("t4_idx", bus.o_note_idx, 4);
    abort();

    // Abort mid-run, then writes during RUN must be ignored
    for (int i = 0; i < 8; i++) wr(i, 100 * (i + 1), (i % 4) + 1, 1000 + i);
    for (int i = 0; i < 5; i++) push(1 << (i % 4), 100 * (i + 1), 1000 + i);
    start(8, 0);
    sweep(0, 550, -1);
    chk("t5_idx5", bus.o_note_idx, 5);
    chk("t5_run_busy", bus.o_busy, 1);
    abort();
    chk("t5_abort_busy", bus.o_busy, 0);
    chk("t5_abort_note", bus.o_note, 0);
    start(8, 0);
    for (int i = 0; i < 8; i++) wr(i, 50, 4, 999);
    abort();
    for (int i = 0; i < 8; i++) push(1 << (i % 4), 100 * (i + 1), 1000 + i);
    start(8, 0);
    sweep(0, 900, -1);
    chk("t5_sb_empty", sb.size(), 0);
    abort();

    // Empty chart ends after the bare end delay
    start(0, 0);
    chk("t6_busy", bus.o_busy, 1);
    sweep(0, 5100, 5000);
    chk("t6_end", bus.o_game_end, 1);
    chk("t6_busy_done", bus.o_busy, 0);
    bus.i_abort = 1'b1;
    bus.i_start = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    bus.i_start = 1'b0;
    chk("t6_abort_wins_busy", bus.o_busy, 0);
    chk("t6_abort_wins_end", bus.o_game_end, 0);

`ifdef CHART_LOOP_EN
    // Looping: second pass offset by last_time + gap, then a normal ending
    bus.i_loop = 1'b1;
    wr(0, 100, 1, 1);
    wr(1, 200, 2, 2);
    push(1, 100, 1);
    push(2, 200, 2);
    push(1, 1300, 1);
    push(2, 1400, 2);
    start(2, 0);
    sweep(0, 1350, -1);
    bus.i_loop = 1'b0;
    sweep(1351, 6500, 6400);
    chk("t7_sb_empty", sb.size(), 0);
    chk("t7_end", bus.o_game_end, 1);
    abort();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
